// File: rtl/packet_slot_manager_pkg.sv
// Shared slot types for the packet slot manager and the packet controller around it.
// The default slot count lives here so that every user sizes its indices the same way.
package packet_slot_manager_pkg;

  localparam int DEFAULT_NUM_ENTRIES = 8;
  localparam int DEFAULT_IDX_W       = $clog2(DEFAULT_NUM_ENTRIES);

  typedef logic [DEFAULT_IDX_W-1:0] slot_index_t;
  typedef logic [DEFAULT_IDX_W:0]   slot_count_t;

endpackage

// File: rtl/packet_slot_manager_next_free_index_comb.sv
// Lowest-set-bit finder over the free bitmap. It drives the allocation offer, which means the offer
// depends only on registered state.
module next_free_index_comb #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] i_free_bitmap,
  output logic                   o_valid,
  output logic [IDX_W-1:0]       o_index
);

  // Scanning from the top down lets the lowest free index be the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (i_free_bitmap[i]) begin
        o_valid = 1'b1;
        o_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/packet_slot_manager.sv
// Free/used bookkeeping for the packet buffer slots: lowest-free allocation and release on drain.
// Define PACKET_SLOT_DOUBLE_FREE_CHECK_EN to add the sticky double_free_err output.
module packet_slot_manager
  import packet_slot_manager_pkg::*;
#(
  parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
  localparam int IDX_W      = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             alloc_valid,
  output logic [IDX_W-1:0] alloc_index,
  input  logic             alloc_ready,
  input  logic             release_valid,
  input  logic [IDX_W-1:0] release_index,
  output logic [IDX_W:0]   free_count,
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
  output logic             double_free_err,
`endif
  output logic             full
);

  logic [NUM_ENTRIES-1:0] r_free_bitmap;
  logic [IDX_W:0]         r_free_count;
  logic                   r_full;

  logic [NUM_ENTRIES-1:0] w_bitmap_next;
  logic [IDX_W:0]         w_count_next;
  logic                   w_alloc_fire;
  logic                   w_release_eff;

  next_free_index_comb #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_next_free (
    .i_free_bitmap (r_free_bitmap),
    .o_valid       (alloc_valid),
    .o_index       (alloc_index)
  );

  assign w_alloc_fire  = alloc_valid & alloc_ready;
  assign w_release_eff = release_valid & ~r_free_bitmap[release_index];

  // Allocation is applied after release so a same-index collision leaves the slot used.
  always_comb begin
    w_bitmap_next = r_free_bitmap;
    if (release_valid) w_bitmap_next[release_index] = 1'b1;
    if (w_alloc_fire)  w_bitmap_next[alloc_index]   = 1'b0;
  end

  assign w_count_next = r_free_count - (IDX_W+1)'(w_alloc_fire) + (IDX_W+1)'(w_release_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free_bitmap <= '1;
      r_free_count  <= (IDX_W+1)'(NUM_ENTRIES);
      r_full        <= 1'b0;
    end else begin
      r_free_bitmap <= w_bitmap_next;
      r_free_count  <= w_count_next;
      r_full        <= (w_count_next == '0);
    end
  end

  assign free_count = r_free_count;
  assign full       = r_full;

`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
  logic r_double_free_err;
  logic w_double_free;

  assign w_double_free = release_valid & r_free_bitmap[release_index];

  always_ff @(posedge clk) begin
    if (rst) r_double_free_err <= 1'b0;
    else     r_double_free_err <= r_double_free_err | w_double_free;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!w_double_free)
        else $error("packet_slot_manager: double free of slot %0d", release_index);
    end
  end

  assign double_free_err = r_double_free_err;
`endif

endmodule

// File: tb/tb_packet_slot_manager.sv
// Directed bench for packet_slot_manager: stimulus pushes expected state and grants into queues,
// and negedge monitors pop and compare them against what the DUT presents.
module tb_packet_slot_manager;
  import packet_slot_manager_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  slot_index_t alloc_index;
  logic        alloc_ready;
  logic        release_valid;
  slot_index_t release_index;
  slot_count_t free_count;
  logic        full;
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
  logic        double_free_err;
`endif

  packet_slot_manager #(.NUM_ENTRIES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_index     (alloc_index),
    .alloc_ready     (alloc_ready),
    .release_valid   (release_valid),
    .release_index   (release_index),
    .free_count      (free_count),
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
    .double_free_err (double_free_err),
`endif
    .full            (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        av;
    logic        chk_ai;
    slot_index_t ai;
    slot_count_t fc;
    logic        fl;
    logic        dfe;
  } exp_t;

  exp_t        exp_q[$];
  slot_index_t grant_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // State monitor: everything pushed during this cycle is compared at the falling edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".alloc_valid"}, int'(alloc_valid), int'(e.av));
      if (e.chk_ai) chk({e.name, ".alloc_index"}, int'(alloc_index), int'(e.ai));
      chk({e.name, ".free_count"}, int'(free_count), int'(e.fc));
      chk({e.name, ".full"}, int'(full), int'(e.fl));
`ifdef PACKET_SLOT_DOUBLE_FREE_CHECK_EN
      chk({e.name, ".double_free_err"}, int'(double_free_err), int'(e.dfe));
`endif
    end
  end

  // Grant monitor: a handshake visible at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && alloc_valid && alloc_ready) begin
      if (grant_q.size() == 0) begin
        chk("unexpected_grant", int'(alloc_index), -1);
      end else begin
        slot_index_t g;
        g = grant_q.pop_front();
        chk("grant_index", int'(alloc_index), int'(g));
      end
    end
  end

  task automatic expect_state(input string name, input logic av, input logic chk_ai,
                              input int ai, input int fc, input logic fl, input logic dfe);
    exp_t e;
    e.name = name; e.av = av; e.chk_ai = chk_ai; e.ai = slot_index_t'(ai);
    e.fc = slot_count_t'(fc); e.fl = fl; e.dfe = dfe;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alloc_ready = 1'b0; release_valid = 1'b0; release_index = '0;
    step(); step();
    rst = 1'b0;
    expect_state("reset", 1'b1, 1'b1, 0, 8, 1'b0, 1'b0);

    // Fill every slot in ascending order.
    alloc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      grant_q.push_back(slot_index_t'(i));
      step();
      if (i == 7) alloc_ready = 1'b0;
      expect_state($sformatf("fill%0d", i), i != 7, i != 7, i + 1, 7 - i, i == 7, 1'b0);
    end

    // Release 5 then 2 from full.
    release_valid = 1'b1; release_index = 3'd5;
    step();
    release_index = 3'd2;
    expect_state("rel5", 1'b1, 1'b1, 5, 1, 1'b0, 1'b0);
    step();
    release_valid = 1'b0;
    expect_state("rel2", 1'b1, 1'b1, 2, 2, 1'b0, 1'b0);

    // Back to full, then free only slot 3.
    alloc_ready = 1'b1;
    grant_q.push_back(3'd2);
    step();
    expect_state("take2", 1'b1, 1'b1, 5, 1, 1'b0, 1'b0);
    grant_q.push_back(3'd5);
    step();
    alloc_ready = 1'b0;
    expect_state("take5", 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    release_valid = 1'b1; release_index = 3'd3;
    step();
    release_valid = 1'b0;
    expect_state("rel3", 1'b1, 1'b1, 3, 1, 1'b0, 1'b0);

    // Allocate 3 while releasing used slot 6 in the same cycle.
    alloc_ready = 1'b1; grant_q.push_back(3'd3);
    release_valid = 1'b1; release_index = 3'd6;
    step();
    alloc_ready = 1'b0; release_valid = 1'b0;
    expect_state("alloc3_rel6", 1'b1, 1'b1, 6, 1, 1'b0, 1'b0);

    // Free slot 1, then release it again (double free).
    release_valid = 1'b1; release_index = 3'd1;
    step();
    expect_state("rel1", 1'b1, 1'b1, 1, 2, 1'b0, 1'b0);
    step();
    release_valid = 1'b0;
    expect_state("dbl_free1", 1'b1, 1'b1, 1, 2, 1'b0, 1'b1);
    step();
    expect_state("dbl_free_hold", 1'b1, 1'b1, 1, 2, 1'b0, 1'b1);

    // Same-index collision: allocation of 1 wins over its double release.
    alloc_ready = 1'b1; grant_q.push_back(3'd1);
    release_valid = 1'b1; release_index = 3'd1;
    step();
    alloc_ready = 1'b0; release_valid = 1'b0;
    expect_state("collide1", 1'b1, 1'b1, 6, 1, 1'b0, 1'b1);

    // Free 0 and 4 to reach 5 used, then reset mid-operation.
    release_valid = 1'b1; release_index = 3'd0;
    step();
    release_index = 3'd4;
    step();
    release_valid = 1'b0;
    expect_state("five_used", 1'b1, 1'b1, 0, 3, 1'b0, 1'b1);
    rst = 1'b1; alloc_ready = 1'b1;
    step();
    rst = 1'b0; alloc_ready = 1'b0;
    expect_state("mid_reset", 1'b1, 1'b1, 0, 8, 1'b0, 1'b0);

    step(); step();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("grant_q_drained", grant_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
